cache_fill_fsm: RTL

- Miss-handling controller on the fill side of the 2-way cache; the cache raises miss, this block services it.
- On a miss it latches the block-aligned miss address and streams 8 sequential 16-bit word reads to pipelined main memory.
- Each returned word is written into the cache data array at the matching word offset, then a single tag/metadata write commits the block.
- The CPU pipeline stalls on fsm_busy.

---
 rtl/cache_fill_fsm.sv | 98 +++++++++
 1 files changed

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: services a cache miss by streaming one block of words from pipelined
// memory into the data array, then committing the block with a single tag write.
module cache_fill_fsm #(
    parameter int WORDS    = 8,
    parameter int OFF_BITS = 4,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [ADDR_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              memory_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic [ADDR_W-1:0] data_out
);
    localparam int CW = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_BITS) - 1);

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    state_t state, state_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [CW-1:0] issue_cnt, issue_cnt_n, ret_cnt, ret_cnt_n;
    logic issue_done, issue_done_n;
    logic [ADDR_W-1:0] issue_off, ret_off;

    // Word index to byte offset; base has its offset bits clear, so the sum never carries out of the block.
    assign issue_off = {{(ADDR_W-CW-1){1'b0}}, issue_cnt, 1'b0};
    assign ret_off   = {{(ADDR_W-CW-1){1'b0}}, ret_cnt, 1'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            base       <= '0;
            issue_cnt  <= '0;
            issue_done <= 1'b0;
            ret_cnt    <= '0;
        end else begin
            state      <= state_n;
            base       <= base_n;
            issue_cnt  <= issue_cnt_n;
            issue_done <= issue_done_n;
            ret_cnt    <= ret_cnt_n;
        end
    end

    always_comb begin
        state_n          = state;
        base_n           = base;
        issue_cnt_n      = issue_cnt;
        issue_done_n     = issue_done;
        ret_cnt_n        = ret_cnt;
        fsm_busy         = state != IDLE;
        memory_read_en   = 1'b0;
        memory_address   = base + issue_off;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_address     = base + ret_off;
        data_out         = '0;
        case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_n      = FILL;
                    base_n       = miss_address & ~OFF_MASK;
                    issue_cnt_n  = '0;
                    issue_done_n = 1'b0;
                    ret_cnt_n    = '0;
                end
            end
            FILL: begin
                memory_read_en = !issue_done;
                // The issue counter parks on the last word; the done flag blocks a ninth request.
                if (!issue_done) begin
                    issue_done_n = &issue_cnt;
                    issue_cnt_n  = (&issue_cnt) ? issue_cnt : issue_cnt + 1'b1;
                end
                write_data_array = memory_data_valid;
                data_out         = memory_data_valid ? memory_data : '0;
                if (memory_data_valid) begin
                    ret_cnt_n = ret_cnt + 1'b1;
                    state_n   = (&ret_cnt) ? COMMIT : FILL;
                end
            end
            COMMIT: begin
                write_tag_array = 1'b1;
                fill_address    = base;
                state_n         = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
